// File: rtl/cpu_types_pkg.sv
// Shared types for the cache/RAM interface and the memory arbiter.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_picker2.sv
// Two-way round-robin picker: ptr names the core that wins when both request.
module rr_picker2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] win,
    output logic       valid
);

    assign win[0] = req[0] & (~ptr | ~req[1]);
    assign win[1] = req[1] & (ptr | ~req[0]);
    assign valid  = |req;

endmodule

// File: rtl/mem_arbiter.sv
// Serialises dcache/icache requests from two cores onto the single-port RAM.
import cpu_types_pkg::*;

module mem_arbiter #(
    parameter int NUM_CPUS = 2
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic      [NUM_CPUS-1:0]   iREN,
    input  word_t     [NUM_CPUS-1:0]   iaddr,
    output logic      [NUM_CPUS-1:0]   iwait,
    output word_t     [NUM_CPUS-1:0]   iload,
    input  logic      [NUM_CPUS-1:0]   dREN,
    input  logic      [NUM_CPUS-1:0]   dWEN,
    input  word_t     [NUM_CPUS-1:0]   daddr,
    input  word_t     [NUM_CPUS-1:0]   dstore,
    output logic      [NUM_CPUS-1:0]   dwait,
    output word_t     [NUM_CPUS-1:0]   dload,
    output logic                       ramREN,
    output logic                       ramWEN,
    output word_t                      ramaddr,
    output word_t                      ramstore,
    input  word_t                      ramload,
    input  ramstate_t                  ramstate
);

    arb_state_t state;
    logic       grant_id;
    logic       grant_is_d;
    logic       dptr;
    logic       iptr;

    logic [1:0] d_req;
    logic [1:0] d_win;
    logic [1:0] i_win;
    logic       d_valid;
    logic       i_valid;
    logic       live;
    logic       active;
    logic       is_wr;
    logic       done;

    assign d_req = dREN | dWEN;

    rr_picker2 u_d_pick (
        .req   (d_req),
        .ptr   (dptr),
        .win   (d_win),
        .valid (d_valid)
    );

    rr_picker2 u_i_pick (
        .req   (iREN),
        .ptr   (iptr),
        .win   (i_win),
        .valid (i_valid)
    );

    // Everything downstream is gated by the live request so an abort drops the strobe at once.
    assign live   = grant_is_d ? d_req[grant_id] : iREN[grant_id];
    assign active = (state == GRANT) && live;
    assign is_wr  = grant_is_d && dWEN[grant_id];
    assign done   = active && (ramstate == ACCESS);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            grant_id   <= 1'b0;
            grant_is_d <= 1'b0;
            dptr       <= 1'b0;
            iptr       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (d_valid) begin
                        grant_is_d <= 1'b1;
                        grant_id   <= d_win[1];
                        state      <= GRANT;
                    end else if (i_valid) begin
                        grant_is_d <= 1'b0;
                        grant_id   <= i_win[1];
                        state      <= GRANT;
                    end
                end
                GRANT: begin
                    if (!live) begin
                        state <= IDLE;
                    end else if (ramstate == ACCESS) begin
                        state <= IDLE;
                        if (grant_is_d) dptr <= ~grant_id;
                        else            iptr <= ~grant_id;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        iwait    = '1;
        dwait    = '1;
        iload    = '0;
        dload    = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        if (active) begin
            ramWEN   = is_wr;
            ramREN   = ~is_wr;
            ramaddr  = grant_is_d ? daddr[grant_id] : iaddr[grant_id];
            ramstore = is_wr ? dstore[grant_id] : '0;
        end
        if (done) begin
            if (grant_is_d) begin
                dwait[grant_id] = 1'b0;
                dload[grant_id] = ramload;
            end else begin
                iwait[grant_id] = 1'b0;
                iload[grant_id] = ramload;
            end
        end
    end

endmodule
